// File: rtl/mux4_arb_pkg.sv
// Shared constants, state encoding and helpers for the MUX4 round-robin arbiter.
package mux4_arb_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin search: first set request at ptr, ptr+1, ptr+2, ptr+3 (mod 4).
module rr_pick4
    import mux4_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic [SEL_W-1:0] ptr_i,
    output logic             found_o,
    output logic [SEL_W-1:0] idx_o
);

    logic [SEL_W-1:0] cand;

    always_comb begin
        found_o = 1'b0;
        idx_o   = ptr_i;
        cand    = ptr_i;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = ptr_i + SEL_W'(k);
            if (!found_o && req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Four-requester round-robin arbiter with bounded hold time, driving the SEL of a shared MUX4.
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [N_REQ-1:0] REQ,
    output logic [N_REQ-1:0] GNT,
    output logic [SEL_W-1:0] SEL,
    output logic             BUSY
);

    localparam int unsigned HCNT_W = $clog2(MAX_HOLD);
    localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(MAX_HOLD - 1);

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             busy_q, busy_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [HCNT_W-1:0] hcnt_q, hcnt_d;

    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;
    logic             own_req;
    logic             issue;
    logic [SEL_W-1:0] win;

    // gnt_q is zero in IDLE, so masking it out only excludes the owner while granted
    rr_pick4 u_pick (
        .req_i   (REQ & ~gnt_q),
        .ptr_i   (ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    assign own_req = |(REQ & gnt_q);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        hcnt_d  = hcnt_q;
        issue   = 1'b0;
        win     = pick_idx;

        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    issue = 1'b1;
                end
            end
            GRANT: begin
                if (own_req && (hcnt_q < HOLD_LAST)) begin
                    hcnt_d = hcnt_q + HCNT_W'(1);
                end else if (pick_found) begin
                    issue = 1'b1;
                end else if (own_req) begin
                    // Hold limit reached with nobody else waiting: re-grant the sole requester
                    issue = 1'b1;
                    win   = sel_q;
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase

        if (issue) begin
            state_d = GRANT;
            gnt_d   = onehot(win);
            sel_d   = win;
            ptr_d   = win + SEL_W'(1);
            hcnt_d  = '0;
        end

        busy_d = |gnt_d;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
            hcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
            hcnt_q  <= hcnt_d;
        end
    end

    assign GNT  = gnt_q;
    assign SEL  = sel_q;
    assign BUSY = busy_q;

endmodule
